// File: rtl/memory_stage_pkg.sv
// Shared types for the RV32I MEM stage: access-size encoding, FSM states and
// the control bundle carried from EX/MEM into MEM/WB.
package memory_stage_pkg;

   localparam logic [1:0] MEM_NONE = 2'b00;
   localparam logic [1:0] MEM_B    = 2'b01;
   localparam logic [1:0] MEM_H    = 2'b10;
   localparam logic [1:0] MEM_W    = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_t;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] wb_sel;
      logic [1:0] mem_read;
      logic [1:0] mem_write;
      logic       mem_unsigned;
      logic [4:0] rd;
   } control_t;

   // Halves need an even address, words a multiple of four; bytes never fault.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      return ((size == MEM_H) && off[0]) || ((size == MEM_W) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// Picks the byte/half/word addressed by addr[1:0] out of a read word and
// sign- or zero-extends it to 32 bits.
module load_align
   import memory_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [1:0]  size,
   input  logic        uns,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case can leave a value held and infer a latch.
   always_comb begin
      byte_sel = rdata[{addr, 3'b000} +: 8];
      half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
      data     = '0;
      case (size)
         MEM_B:   data = {{24{~uns & byte_sel[7]}}, byte_sel};
         MEM_H:   data = {{16{~uns & half_sel[15]}}, half_sel};
         MEM_W:   data = rdata;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: drives the data bus with a valid/ready handshake and timeout,
// aligns store lanes, extends load data and owns the MEM/WB register.
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  control_t    control_in,
   input  logic [31:0] pc_in,
   input  logic [31:0] alu_res_in,
   input  logic [31:0] store_data_in,
   input  logic        flush,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        valid_wb,
   output control_t    control,
   output logic [31:0] pc_wb,
   output logic [31:0] alu_res,
   output logic [31:0] mem_data,
   output logic        bus_err,
   output logic        misaligned
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   mem_state_t    state, state_nx;
   logic [CW-1:0] cnt;

   // Transaction attributes captured at issue, used to extract the read word.
   logic [1:0]    lat_off;
   logic [1:0]    lat_size;
   logic          lat_uns;
   logic          lat_load;

   logic [1:0]    size;
   logic [1:0]    off;
   logic          is_load;
   logic          is_access;
   logic          is_mis;
   logic          aligned_access;
   logic          at_limit;
   logic          complete;
   logic          timed_out;
   logic          bubble;
   logic [31:0]   wdata_nx;
   logic [3:0]    wstrb_nx;
   logic [31:0]   load_val;
   control_t      ctl_wb;
   logic [31:0]   data_wb;

   always_comb begin
      is_load        = (control_in.mem_read != MEM_NONE);
      size           = is_load ? control_in.mem_read : control_in.mem_write;
      off            = alu_res_in[1:0];
      is_access      = valid_in && (is_load || (control_in.mem_write != MEM_NONE));
      is_mis         = is_access && is_misaligned(size, off);
      aligned_access = is_access && !is_mis;
      at_limit       = (cnt == CW'(TIMEOUT - 1));
      complete       = (state == BUSY) && (mem_ready || at_limit);
      timed_out      = (state == BUSY) && !mem_ready && at_limit;
      stall          = aligned_access && !complete;
      bubble         = stall || flush || !valid_in;
   end

   always_comb begin
      wdata_nx = store_data_in;
      wstrb_nx = 4'b0000;
      case (size)
         MEM_B: begin
            wdata_nx = {4{store_data_in[7:0]}};
            wstrb_nx = 4'b0001 << off;
         end
         MEM_H: begin
            wdata_nx = {2{store_data_in[15:0]}};
            wstrb_nx = 4'b0011 << off;
         end
         MEM_W: wstrb_nx = 4'b1111;
         default: wstrb_nx = 4'b0000;
      endcase
      if (is_load) wstrb_nx = 4'b0000;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (aligned_access) state_nx = BUSY;
         BUSY:    if (complete)       state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: state registers use nonblocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         cnt       <= '0;
         lat_off   <= '0;
         lat_size  <= '0;
         lat_uns   <= 1'b0;
         lat_load  <= 1'b0;
      end else if (state == IDLE) begin
         if (aligned_access) begin
            mem_req   <= 1'b1;
            mem_we    <= !is_load;
            mem_addr  <= {alu_res_in[31:2], 2'b00};
            mem_wdata <= wdata_nx;
            mem_wstrb <= wstrb_nx;
            cnt       <= '0;
            lat_off   <= off;
            lat_size  <= size;
            lat_uns   <= control_in.mem_unsigned;
            lat_load  <= is_load;
         end
      end else if (complete) begin
         mem_req <= 1'b0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   load_align u_load_align (
      .rdata (mem_rdata),
      .addr  (lat_off),
      .size  (lat_size),
      .uns   (lat_uns),
      .data  (load_val)
   );

   // Faulted accesses reach writeback with the memory fields cleared.
   always_comb begin
      ctl_wb  = control_in;
      data_wb = '0;
      if (is_mis || (aligned_access && timed_out)) begin
         ctl_wb.mem_read  = MEM_NONE;
         ctl_wb.mem_write = MEM_NONE;
      end
      if (aligned_access && (state == BUSY) && mem_ready && lat_load) data_wb = load_val;
   end

   // NOTE: only control and status flops live here, so all of them take the
   // asynchronous reset; there is no memory array to leave unreset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || bubble) begin
         valid_wb   <= 1'b0;
         control    <= '0;
         pc_wb      <= '0;
         alu_res    <= '0;
         mem_data   <= '0;
         bus_err    <= 1'b0;
         misaligned <= 1'b0;
      end else begin
         valid_wb   <= 1'b1;
         control    <= ctl_wb;
         pc_wb      <= pc_in;
         alu_res    <= alu_res_in;
         mem_data   <= data_wb;
         bus_err    <= aligned_access && timed_out;
         misaligned <= is_mis;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed plan cases plus random
// instructions checked against a transaction-level model of the stage.
module tb_memory_stage;
   import memory_stage_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   control_t    control_in;
   logic [31:0] pc_in, alu_res_in, store_data_in;
   logic        flush;
   logic        stall, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        valid_wb;
   control_t    control;
   logic [31:0] pc_wb, alu_res, mem_data;
   logic        bus_err, misaligned;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   memory_stage #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .control_in(control_in),
      .pc_in(pc_in), .alu_res_in(alu_res_in), .store_data_in(store_data_in),
      .flush(flush), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .valid_wb(valid_wb),
      .control(control), .pc_wb(pc_wb), .alu_res(alu_res), .mem_data(mem_data),
      .bus_err(bus_err), .misaligned(misaligned)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic control_t mk_ctl(input int rd_sz, input int wr_sz, input bit uns);
      control_t c;
      c.reg_write    = 1'($urandom_range(0, 1));
      c.wb_sel       = 2'($urandom_range(0, 3));
      c.mem_read     = 2'(rd_sz);
      c.mem_write    = 2'(wr_sz);
      c.mem_unsigned = uns;
      c.rd           = 5'($urandom_range(0, 31));
      return c;
   endfunction

   // Reference extraction: shift the word down, mask to the access width,
   // then reinterpret as signed when asked.
   function automatic logic [31:0] ref_load(input logic [31:0] w, input int off,
                                            input int sz, input bit uns);
      longint v;
      int     bits;
      if (sz == 3) return w;
      bits = (sz == 1) ? 8 : 16;
      v = longint'(w >> (8 * off)) & ((longint'(1) << bits) - 1);
      if (!uns && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
      return 32'(v);
   endfunction

   // Presents one instruction in EX/MEM, plays the bus with n_wait low-ready
   // cycles, then checks the MEM/WB result one edge after the model says so.
   task automatic run_instr(input control_t ctl, input logic [31:0] pc, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [31:0] rdata,
                            input int n_wait, input bit fl_last);
      int       sz, off, total;
      bit       acc, ld, mis, tmo, busy_k, rdy_k;
      control_t exp_ctl;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_wstrb;

      ld  = (ctl.mem_read != 0);
      acc = ld || (ctl.mem_write != 0);
      sz  = ld ? int'(ctl.mem_read) : int'(ctl.mem_write);
      off = int'(addr % 4);
      mis = acc && ((sz == 2 && off % 2 == 1) || (sz == 3 && off != 0));
      tmo = acc && !mis && n_wait >= TO;
      total = (!acc || mis) ? 1 : (tmo ? 1 + TO : 2 + n_wait);
      exp_wdata = (sz == 1) ? (sdata & 32'hFF) * 32'h0101_0101 :
                  (sz == 2) ? (sdata & 32'hFFFF) * 32'h0001_0001 : sdata;
      exp_wstrb = (sz == 1) ? 4'(1 << off) : (sz == 2) ? 4'(3 << off) : 4'hF;

      valid_in      = 1'b1;
      control_in    = ctl;
      pc_in         = pc;
      alu_res_in    = addr;
      store_data_in = sdata;
      for (int k = 0; k < total; k++) begin
         busy_k    = acc && !mis && k >= 1;
         rdy_k     = busy_k && (k - 1 == n_wait);
         mem_ready = busy_k ? rdy_k : 1'($urandom_range(0, 1));
         mem_rdata = rdy_k ? rdata : $urandom;
         flush     = (k == total - 1) ? fl_last : 1'($urandom_range(0, 1));
         @(negedge clk);
         check("stall", 32'(stall), 32'(k != total - 1));
         check("mem_req", 32'(mem_req), 32'(busy_k));
         if (k >= 1) check("valid_wb_during_stall", 32'(valid_wb), 32'd0);
         if (busy_k) begin
            check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
            check("mem_we", 32'(mem_we), 32'(!ld));
            if (!ld) begin
               check("mem_wdata", mem_wdata, exp_wdata);
               check("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
            end
         end
         @(posedge clk);
         #1;
      end

      if (fl_last) begin
         check("flush_valid_wb", 32'(valid_wb), 32'd0);
         check("flush_control", 32'(control), 32'd0);
         check("flush_bus_err", 32'(bus_err), 32'd0);
         check("flush_misaligned", 32'(misaligned), 32'd0);
      end else begin
         exp_ctl = ctl;
         if (mis || tmo) begin
            exp_ctl.mem_read  = 2'b00;
            exp_ctl.mem_write = 2'b00;
         end
         check("valid_wb", 32'(valid_wb), 32'd1);
         check("control", 32'(control), 32'(exp_ctl));
         check("pc_wb", pc_wb, pc);
         check("alu_res", alu_res, addr);
         check("mem_data", mem_data,
               (ld && !mis && !tmo) ? ref_load(rdata, off, sz, ctl.mem_unsigned) : 32'd0);
         check("bus_err", 32'(bus_err), 32'(tmo));
         check("misaligned", 32'(misaligned), 32'(mis));
         check("mem_req_dropped", 32'(mem_req), 32'd0);
      end
   endtask

   task automatic idle_cycle();
      valid_in   = 1'b0;
      control_in = mk_ctl($urandom_range(0, 3), 0, 1'b0);
      flush      = 1'($urandom_range(0, 1));
      mem_ready  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      check("idle_valid_wb", 32'(valid_wb), 32'd0);
      check("idle_control", 32'(control), 32'd0);
   endtask

   initial begin
      int kind, sz, nw;
      logic [31:0] a;

      rst = 1'b1;
      valid_in = 1'b0; control_in = '0; pc_in = '0; alu_res_in = '0;
      store_data_in = '0; flush = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_valid_wb", 32'(valid_wb), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_control", 32'(control), 32'd0);
      check("rst_flags", {30'd0, bus_err, misaligned}, 32'd0);
      rst = 1'b0;

      run_instr(mk_ctl(3, 0, 1'b0), 32'h1000, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
      run_instr(mk_ctl(1, 0, 1'b0), 32'h1004, 32'h103, 32'h0, 32'h80FF_0000, 0, 1'b0);
      run_instr(mk_ctl(1, 0, 1'b1), 32'h1008, 32'h103, 32'h0, 32'h80FF_0000, 0, 1'b0);
      run_instr(mk_ctl(0, 2, 1'b0), 32'h100C, 32'h202, 32'h1234_ABCD, 32'h0, 0, 1'b0);
      run_instr(mk_ctl(3, 0, 1'b0), 32'h1010, 32'h400, 32'h0, 32'h1357_9BDF, 3, 1'b0);
      run_instr(mk_ctl(3, 0, 1'b0), 32'h1014, 32'h404, 32'h0, 32'h0, TO + 5, 1'b0);
      run_instr(mk_ctl(3, 0, 1'b0), 32'h1018, 32'h102, 32'h0, 32'h0, 0, 1'b0);
      run_instr(mk_ctl(2, 0, 1'b0), 32'h101C, 32'h506, 32'h0, 32'h8001_7FFF, TO - 1, 1'b0);
      run_instr(mk_ctl(0, 0, 1'b0), 32'h1020, 32'hCAFE_F00D, 32'h0, 32'h0, 0, 1'b0);
      run_instr(mk_ctl(3, 0, 1'b0), 32'h1024, 32'h600, 32'h0, 32'h2468_ACE0, 1, 1'b1);
      idle_cycle();

      for (int i = 0; i < 300; i++) begin
         kind = $urandom_range(0, 3);
         sz   = $urandom_range(1, 3);
         a    = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         nw   = $urandom_range(0, TO + 1);
         if (kind == 3) idle_cycle();
         else run_instr(mk_ctl(kind == 1 ? sz : 0, kind == 2 ? sz : 0, 1'($urandom_range(0, 1))),
                        $urandom, a, $urandom, $urandom, nw, ($urandom_range(0, 7) == 0));
      end

      // Reset in the middle of a transaction abandons it at once.
      valid_in = 1'b1; control_in = mk_ctl(3, 0, 1'b0); alu_res_in = 32'h300;
      mem_ready = 1'b0; flush = 1'b0;
      @(posedge clk);
      #1;
      check("busy_mem_req", 32'(mem_req), 32'd1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("midrst_mem_req", 32'(mem_req), 32'd0);
      check("midrst_mem_addr", mem_addr, 32'd0);
      check("midrst_valid_wb", 32'(valid_wb), 32'd0);
      check("midrst_flags", {30'd0, bus_err, misaligned}, 32'd0);
      valid_in = 1'b0;
      #1;
      check("midrst_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_instr(mk_ctl(3, 0, 1'b0), 32'h2000, 32'h700, 32'h0, 32'h0BAD_F00D, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
